// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: DEPTH-entry circular FIFO feeding a registered decoder-facing output stage.
// Optional macro INSTR_BYPASS_EN lets a LOAD into an idle, empty queue land directly in INSTR.
module instr_fetch_queue #(
  parameter int DEPTH = 8,
  parameter int IW    = 10
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [IW-1:0]            DIN,
  input  logic                     LOAD,
  input  logic                     NEXT,
  output logic [IW-1:0]            INSTR,
  output logic                     VALID,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic                     OVERFLOW,
  output logic [7:0]               PC
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HOLD  = 1'b1
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   instr_q;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      pc_q, pc_d;
  logic [IW-1:0]   mem_q [DEPTH];

  logic            full;
  logic            fifo_nz;
  logic            consume;
  logic            pop;
  logic            push;
  logic            byp;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    fifo_nz  = (count_q != '0);
    consume  = (state_q == S_HOLD) && NEXT;
    // The output register refills whenever it is (or is about to become) free.
    pop      = fifo_nz && ((state_q == S_EMPTY) || consume);
`ifdef INSTR_BYPASS_EN
    byp      = LOAD && !fifo_nz && ((state_q == S_EMPTY) || consume);
`else
    byp      = 1'b0;
`endif
    push     = LOAD && !full && !byp;
    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    ovf_d    = ovf_q | (LOAD && full);
    pc_d     = consume ? pc_q + 8'd1 : pc_q;
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= DIN;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= S_EMPTY;
      instr_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      pc_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      pc_q     <= pc_d;
      case (state_q)
        S_EMPTY: begin
          if (byp) begin
            instr_q <= DIN;
            state_q <= S_HOLD;
          end else if (pop) begin
            instr_q <= mem_q[rd_ptr_q];
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          // INSTR keeps its last value when the queue runs dry.
          if (consume) begin
            if (byp) begin
              instr_q <= DIN;
            end else if (pop) begin
              instr_q <= mem_q[rd_ptr_q];
            end else begin
              state_q <= S_EMPTY;
            end
          end
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

  assign INSTR    = instr_q;
  assign VALID    = (state_q == S_HOLD);
  assign COUNT    = count_q;
  assign FULL     = full;
  assign EMPTY    = !fifo_nz && (state_q == S_EMPTY);
  assign OVERFLOW = ovf_q;
  assign PC       = pc_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: stimulus queues expected issue order, a monitor checks each consumed INSTR.
module tb_instr_fetch_queue;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [9:0]  DIN;
  logic        LOAD;
  logic        NEXT;
  logic [9:0]  INSTR;
  logic        VALID;
  logic [3:0]  COUNT;
  logic        FULL;
  logic        EMPTY;
  logic        OVERFLOW;
  logic [7:0]  PC;

  int n_tests = 0;
  int n_fail  = 0;
  logic [9:0] exp_q[$];

  always #5 CLK = ~CLK;

  instr_fetch_queue #(.DEPTH(8), .IW(10)) dut (
    .CLK(CLK), .RST_N(RST_N), .DIN(DIN), .LOAD(LOAD), .NEXT(NEXT),
    .INSTR(INSTR), .VALID(VALID), .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY),
    .OVERFLOW(OVERFLOW), .PC(PC)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: an instruction presented with NEXT high is consumed at the coming edge.
  always @(negedge CLK) begin
    if (RST_N === 1'b1 && VALID === 1'b1 && NEXT === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL issue_unexpected: got %0h expected none", INSTR);
      end else begin
        chk("issue_order", {22'd0, INSTR}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0; LOAD = 1'b0; NEXT = 1'b0; DIN = '0;
    cyc();
    RST_N = 1'b1;
    exp_q.delete();
  endtask

  task automatic load(input logic [9:0] v, input bit issued);
    LOAD = 1'b1; DIN = v;
    if (issued) exp_q.push_back(v);
    cyc();
    LOAD = 1'b0;
  endtask

  task automatic drain(input string nm);
    int k;
    NEXT = 1'b1;
    for (k = 0; k < 20; k++) begin
      cyc();
      if (!VALID) break;
    end
    NEXT = 1'b0;
    chk({nm, "_drained_valid"}, {31'd0, VALID}, 32'd0);
    chk({nm, "_queue_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    RST_N = 1'b0; LOAD = 1'b0; NEXT = 1'b0; DIN = '0;
    cyc(); cyc();

    // Reset mid-operation
    do_reset();
    load(10'h011, 1'b1); load(10'h012, 1'b1); load(10'h013, 1'b1);
    do_reset();
    chk("rst_valid", {31'd0, VALID}, 32'd0);
    chk("rst_count", {28'd0, COUNT}, 32'd0);
    chk("rst_empty", {31'd0, EMPTY}, 32'd1);
    chk("rst_full", {31'd0, FULL}, 32'd0);
    chk("rst_pc", {24'd0, PC}, 32'd0);
    chk("rst_ovf", {31'd0, OVERFLOW}, 32'd0);
    chk("rst_instr", {22'd0, INSTR}, 32'd0);
    NEXT = 1'b1; cyc(); NEXT = 1'b0;
    chk("rst_next_pc", {24'd0, PC}, 32'd0);

    // Single instruction latency
    do_reset();
    load(10'b1001000101, 1'b1);
`ifdef INSTR_BYPASS_EN
    chk("single_valid_e0", {31'd0, VALID}, 32'd1);
    chk("single_count_e0", {28'd0, COUNT}, 32'd0);
`else
    chk("single_valid_e0", {31'd0, VALID}, 32'd0);
    chk("single_count_e0", {28'd0, COUNT}, 32'd1);
    chk("single_empty_e0", {31'd0, EMPTY}, 32'd0);
    cyc();
`endif
    chk("single_valid", {31'd0, VALID}, 32'd1);
    chk("single_instr", {22'd0, INSTR}, 32'h245);
    chk("single_count", {28'd0, COUNT}, 32'd0);
    NEXT = 1'b1; cyc(); NEXT = 1'b0;
    chk("single_next_valid", {31'd0, VALID}, 32'd0);
    chk("single_next_pc", {24'd0, PC}, 32'd1);
    chk("single_next_empty", {31'd0, EMPTY}, 32'd1);
    chk("single_hold_instr", {22'd0, INSTR}, 32'h245);

    // Back-to-back issue
    do_reset();
    load(10'h001, 1'b1); load(10'h002, 1'b1); load(10'h003, 1'b1);
    chk("b2b_valid_pre", {31'd0, VALID}, 32'd1);
    NEXT = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("b2b_no_gap", {31'd0, VALID}, 32'd1);
    end
    cyc();
    NEXT = 1'b0;
    chk("b2b_valid_end", {31'd0, VALID}, 32'd0);
    chk("b2b_pc", {24'd0, PC}, 32'd3);
    chk("b2b_queue_empty", exp_q.size(), 32'd0);

    // Full and overflow
    do_reset();
    for (int v = 1; v <= 10; v++) load(10'(v), v <= 9);
    chk("full_instr", {22'd0, INSTR}, 32'd1);
    chk("full_valid", {31'd0, VALID}, 32'd1);
    chk("full_count", {28'd0, COUNT}, 32'd8);
    chk("full_full", {31'd0, FULL}, 32'd1);
    chk("full_ovf", {31'd0, OVERFLOW}, 32'd1);
    LOAD = 1'b1; NEXT = 1'b1; DIN = 10'd11;
    cyc();
    LOAD = 1'b0; NEXT = 1'b0;
    chk("full_no_rescue_count", {28'd0, COUNT}, 32'd7);
    chk("full_no_rescue_full", {31'd0, FULL}, 32'd0);
    drain("full");
    chk("full_pc", {24'd0, PC}, 32'd9);
    chk("full_ovf_sticky", {31'd0, OVERFLOW}, 32'd1);

    // Simultaneous push/pop across pointer wrap
    do_reset();
    for (int v = 0; v < 5; v++) load(10'h100 + 10'(v), 1'b1);
    chk("wrap_count_start", {28'd0, COUNT}, 32'd4);
    for (int i = 0; i < 12; i++) begin
      LOAD = 1'b1; NEXT = 1'b1; DIN = 10'h200 + 10'(i);
      exp_q.push_back(DIN);
      cyc();
      chk("wrap_count_steady", {28'd0, COUNT}, 32'd4);
    end
    LOAD = 1'b0; NEXT = 1'b0;
    chk("wrap_pc", {24'd0, PC}, 32'd12);
    drain("wrap");

    // PC wraps after 256 consumes
    do_reset();
    for (int v = 0; v < 5; v++) load(10'h300 + 10'(v), 1'b1);
    for (int i = 0; i < 256; i++) begin
      LOAD = 1'b1; NEXT = 1'b1; DIN = 10'(i);
      exp_q.push_back(DIN);
      cyc();
      if (i == 254) chk("pc_255", {24'd0, PC}, 32'd255);
    end
    LOAD = 1'b0; NEXT = 1'b0;
    chk("pc_wrap_zero", {24'd0, PC}, 32'd0);
    chk("pc_wrap_count", {28'd0, COUNT}, 32'd4);
    drain("pcwrap");

`ifdef INSTR_BYPASS_EN
    // Direct load into the output register
    do_reset();
    load(10'h3C5, 1'b1);
    chk("byp_valid", {31'd0, VALID}, 32'd1);
    chk("byp_instr", {22'd0, INSTR}, 32'h3C5);
    chk("byp_count", {28'd0, COUNT}, 32'd0);
    LOAD = 1'b1; NEXT = 1'b1; DIN = 10'h0AA;
    exp_q.push_back(DIN);
    cyc();
    LOAD = 1'b0; NEXT = 1'b0;
    chk("byp_hold_instr", {22'd0, INSTR}, 32'h0AA);
    chk("byp_hold_count", {28'd0, COUNT}, 32'd0);
    chk("byp_hold_pc", {24'd0, PC}, 32'd1);
    drain("byp");
`endif

    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
